// File: rtl/pc_unit_if.sv
// Fetch-stage program-counter bus: control inputs from next-PC selection and
// PC/status outputs towards the instruction-memory address port.
interface pc_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             stall_i;
  logic             redirect_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic             trap_i;
  logic             halt_i;
  logic             resume_i;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_plus_o;
  logic             pc_valid_o;
  logic             halted_o;
  logic             misalign_o;
  logic [CNT_W-1:0] adv_cnt_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i, trap_i, halt_i, resume_i,
    input  pc_o, pc_plus_o, pc_valid_o, halted_o, misalign_o, adv_cnt_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i, trap_i, halt_i, resume_i,
    output pc_o, pc_plus_o, pc_valid_o, halted_o, misalign_o, adv_cnt_o
  );
endinterface

// File: rtl/pc_unit.sv
// Fetch-stage program counter: stall hold, redirect, trap vectoring, BOOT/RUN/HALT FSM.
// Optional macro PC_ALIGN_CHK_EN vectors misaligned redirect targets to TRAP_VEC.
module pc_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0004,
  parameter int unsigned     STEP      = 4,
  parameter int unsigned     CNT_W     = 32
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [XLEN-1:0]  STEP_V  = XLEN'(STEP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_r;
  state_e           state_s;
  logic [XLEN-1:0]  pc_r;
  logic [XLEN-1:0]  pc_s;
  logic [CNT_W-1:0] cnt_r;
  logic             adv_s;
  logic             redir_en_s;
  logic             redir_bad_s;
  logic             trap_take_s;
  logic             pc_valid_s;
  logic             halted_s;

  // BOOT ignores redirects; only a trap may move the PC there.
  assign redir_en_s  = bus.redirect_i && (state_r != ST_BOOT);
  assign trap_take_s = bus.trap_i || redir_bad_s;

`ifdef PC_ALIGN_CHK_EN
  function automatic logic misaligned_f(input logic [1:0] low_bits);
    if (STEP == 32'd4) begin
      return low_bits != 2'b00;
    end else if (STEP == 32'd2) begin
      return low_bits[0] != 1'b0;
    end else begin
      return 1'b0;
    end
  endfunction

  logic mis_r;

  assign redir_bad_s = redir_en_s && misaligned_f(bus.redirect_pc_i[1:0]);

  // One-cycle pulse after a misaligned redirect was turned into a trap.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mis_r <= 1'b0;
    end else begin
      mis_r <= redir_bad_s && !bus.trap_i;
    end
  end

  assign bus.misalign_o = mis_r;
`else
  assign redir_bad_s    = 1'b0;
  assign bus.misalign_o = 1'b0;
`endif

  // State, PC and advance-counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_BOOT;
      pc_r    <= RESET_VEC;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      cnt_r   <= adv_s ? (cnt_r + CNT_ONE) : cnt_r;
    end
  end

  // Next-state logic; in HALT halt_i beats resume_i, a trap always resumes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: state_s = ST_RUN;
      ST_RUN: begin
        if (bus.halt_i) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_HALT: begin
        if (trap_take_s) begin
          state_s = ST_RUN;
        end else if (bus.halt_i) begin
          state_s = ST_HALT;
        end else if (bus.resume_i) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: state_s = ST_BOOT;
    endcase
  end

  // Next-PC priority: trap, redirect (also flushes a stall), stall hold, step.
  always_comb begin
    pc_s  = pc_r;
    adv_s = 1'b0;
    if (trap_take_s) begin
      pc_s  = TRAP_VEC;
      adv_s = 1'b1;
    end else if (redir_en_s) begin
      pc_s  = bus.redirect_pc_i;
      adv_s = 1'b1;
    end else if ((state_r == ST_RUN) && !bus.stall_i) begin
      pc_s  = pc_r + STEP_V;
      adv_s = 1'b1;
    end else begin
      pc_s  = pc_r;
      adv_s = 1'b0;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    pc_valid_s = 1'b0;
    halted_s   = 1'b0;
    case (state_r)
      ST_BOOT: begin
        pc_valid_s = 1'b0;
        halted_s   = 1'b0;
      end
      ST_RUN: begin
        pc_valid_s = 1'b1;
        halted_s   = 1'b0;
      end
      ST_HALT: begin
        pc_valid_s = 1'b0;
        halted_s   = 1'b1;
      end
      default: begin
        pc_valid_s = 1'b0;
        halted_s   = 1'b0;
      end
    endcase
  end

  assign bus.pc_o       = pc_r;
  assign bus.pc_plus_o  = pc_r + STEP_V;
  assign bus.pc_valid_o = pc_valid_s;
  assign bus.halted_o   = halted_s;
  assign bus.adv_cnt_o  = cnt_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (default parameters); honours PC_ALIGN_CHK_EN.
module tb_pc_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

  pc_unit u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        trap;
    logic        halt;
    logic        resume;
    logic [31:0] e_pc;
    logic        e_valid;
    logic        e_halted;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                     input logic t, input logic h, input logic rs,
                     input logic [31:0] pc, input logic v, input logic hl, input logic [31:0] c);
    vec_t x;
    x = '{r, s, rd, rp, t, h, rs, pc, v, hl, c};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                       input logic t, input logic h, input logic rs);
    rst_n             = r;
    bus.stall_i       = s;
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rp;
    bus.trap_i        = t;
    bus.halt_i        = h;
    bus.resume_i      = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int row, input logic [31:0] pc, input logic v, input logic hl,
                         input logic mis, input logic [31:0] c);
    chk("pc", row, bus.pc_o, pc);
    chk("pc_plus", row, bus.pc_plus_o, pc + 32'd4);
    chk("valid", row, {31'd0, bus.pc_valid_o}, {31'd0, v});
    chk("halted", row, {31'd0, bus.halted_o}, {31'd0, hl});
    chk("misalign", row, {31'd0, bus.misalign_o}, {31'd0, mis});
    chk("adv_cnt", row, bus.adv_cnt_o, c);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    //   rst   stl   rd    rpc            trp   hlt   res    pc             vld   hltd  cnt
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'd0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'd1);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'd2);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 32'd3);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'd4);
    // stall twice, redirect during the second stall
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 32'd4);
    add(1'b1, 1'b1, 1'b1, 32'h200,      1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 32'd5);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0204, 1'b1, 1'b0, 32'd6);
    // halt at 0x20, hold, resume
    add(1'b1, 1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'd7);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0024, 1'b0, 1'b1, 32'd8);
    for (int i = 0; i < 4; i++)
      add(1'b1, 1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0000_0024, 1'b0, 1'b1, 32'd8);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0024, 1'b1, 1'b0, 32'd8);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0028, 1'b1, 1'b0, 32'd9);
    // trap beats redirect and stall; reset mid-run
    add(1'b1, 1'b1, 1'b1, 32'h300,      1'b1, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'd10);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'd11);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'd0);
    add(1'b1, 1'b0, 1'b1, 32'h500,      1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'd0);
    // wrap at the top of the address space
    add(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd1);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'd2);
    // redirect while halted, halt beats resume, trap leaves HALT
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b1, 32'd3);
    add(1'b1, 1'b0, 1'b1, 32'h80,       1'b0, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 32'd4);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0, 1'b1, 32'd4);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 32'd5);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0, 32'd6);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
            vecs[i].trap, vecs[i].halt, vecs[i].resume);
      tick();
      chk_all(i, vecs[i].e_pc, vecs[i].e_valid, vecs[i].e_halted, 1'b0, vecs[i].e_cnt);
    end

    // misaligned redirect to 0x102 from pc=0x8, count 6
    drive(1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 1'b0);
    tick();
`ifdef PC_ALIGN_CHK_EN
    chk_all(100, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'd7);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all(101, 32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd8);
`else
    chk_all(100, 32'h0000_0102, 1'b1, 1'b0, 1'b0, 32'd7);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all(101, 32'h0000_0106, 1'b1, 1'b0, 1'b0, 32'd8);
`endif

    // trap during BOOT is honoured, and BOOT still ends after one cycle
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all(102, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd1);
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_all(103, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
